// File: rtl/shifter_pkg.sv
// Shared state/direction types for the shift sequencer; no logic, no latency.
// Direction encodings mirror the sign convention of the shift-amount operand.
package shifter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    typedef enum logic {
        DIR_RIGHT = 1'b0,
        DIR_LEFT  = 1'b1
    } dir_e;

    localparam logic [15:0] SHAMT_LEFT1  = 16'h0001;
    localparam logic [15:0] SHAMT_RIGHT1 = 16'hFFFF;

    // A negative (sign bit set) amount shifts right, anything else shifts left.
    function automatic dir_e dir_of(input logic sign_bit);
        return sign_bit ? DIR_RIGHT : DIR_LEFT;
    endfunction

endpackage

// File: rtl/shift_step.sv
// One-bit shifter, purely combinational (zero latency, no flow control).
// Left always zero-fills; right fills with the old MSB unless logical.
module shift_step
    import shifter_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] value,
    input  dir_e             direction,
    input  logic             shiftType,
    output logic [WIDTH-1:0] shifted
);

    always_comb begin
        shifted = value;
        if (direction == DIR_LEFT) begin
            shifted = {value[WIDTH-2:0], 1'b0};
        end else begin
            shifted = {(~shiftType) & value[WIDTH-1], value[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle barrel-free shifter: one bit per SHIFT cycle, done pulses count+1 cycles after start.
// start is accepted only in IDLE; requests while busy or in DONE are dropped, never queued.
module shift_sequencer
    import shifter_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] src,
    input  logic [WIDTH-1:0] shamt,
    input  logic             shiftType,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [WIDTH:0] WIDTH_EXT = (WIDTH + 1)'(WIDTH);

    state_e             state_q,  state_d;
    logic [CNT_W-1:0]   count_q,  count_d;
    logic [WIDTH-1:0]   work_q,   work_d;
    dir_e               dir_q,    dir_d;
    logic               type_q,   type_d;
    logic [WIDTH-1:0]   result_q, result_d;

    logic [WIDTH:0]     mag;
    logic [CNT_W-1:0]   count_load;
    logic [WIDTH-1:0]   step_out;

    // Magnitude needs one extra bit so the most negative amount stays positive.
    always_comb begin
        mag = {1'b0, shamt};
        if (shamt[WIDTH-1]) begin
            mag = {1'b0, ~shamt} + {{WIDTH{1'b0}}, 1'b1};
        end
        count_load = (mag > WIDTH_EXT) ? CNT_W'(WIDTH) : CNT_W'(mag);
    end

    shift_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .value    (work_q),
        .direction(dir_q),
        .shiftType(type_q),
        .shifted  (step_out)
    );

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        work_d   = work_q;
        dir_d    = dir_q;
        type_d   = type_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    work_d = src;
                    dir_d  = dir_of(shamt[WIDTH-1]);
                    type_d = shiftType;
                    count_d = count_load;
                    if (count_load != '0) begin
                        state_d = SHIFT;
                    end else begin
                        state_d  = DONE;
                        result_d = src;
                    end
                end
            end
            SHIFT: begin
                work_d  = step_out;
                count_d = count_q - CNT_W'(1);
                if (count_q == CNT_W'(1)) begin
                    state_d  = DONE;
                    result_d = step_out;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            work_q   <= '0;
            dir_q    <= DIR_RIGHT;
            type_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            work_q   <= work_d;
            dir_q    <= dir_d;
            type_q   <= type_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);
    assign result = result_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench: stimulus pushes expected result and completion cycle, a monitor pops on done.
module tb_shift_sequencer;
    import shifter_pkg::*;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] src = '0;
    logic [W-1:0] shamt = '0;
    logic         shiftType = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;

    shift_sequencer #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .src      (src),
        .shamt    (shamt),
        .shiftType(shiftType),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] res;
        int           cyc;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [W-1:0] s;
        logic [W-1:0] a;
        logic         t;
        logic [W-1:0] r;
        int           n;
    } vec_t;

    vec_t vecs[14] = '{
        '{16'h8001, 16'h0003,     1'b1, 16'h0008, 3},
        '{16'h8000, 16'hFFFC,     1'b0, 16'hF800, 4},
        '{16'h8000, 16'hFFFC,     1'b1, 16'h0800, 4},
        '{16'h1234, 16'h0000,     1'b0, 16'h1234, 0},
        '{16'h8000, 16'h8000,     1'b0, 16'hFFFF, 16},
        '{16'h8000, 16'h0020,     1'b0, 16'h0000, 16},
        '{16'h00F0, SHAMT_LEFT1,  1'b0, 16'h01E0, 1},
        '{16'h8421, SHAMT_RIGHT1, 1'b0, 16'hC210, 1},
        '{16'hF000, SHAMT_RIGHT1, 1'b1, 16'h7800, 1},
        '{16'h0001, 16'h000F,     1'b0, 16'h8000, 15},
        '{16'h4000, 16'hFFF0,     1'b0, 16'h0000, 16},
        '{16'h8000, 16'h0010,     1'b1, 16'h0000, 16},
        '{16'hABCD, 16'h8000,     1'b1, 16'h0000, 16},
        '{16'h8001, SHAMT_RIGHT1, 1'b0, 16'hC000, 1}
    };

    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] last_res = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cyc %0d: got %h, want %h", name, cyc, act, exp);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done at cyc %0d: got done=1 result=%h, want no completion",
                             cyc, result);
                end else begin
                    e = sb.pop_front();
                    chk("done_result", 32'(result), 32'(e.res));
                    chk("done_cycle", cyc, e.cyc);
                end
            end
        end
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got %0d pending completions, want 0", name, sb.size());
            sb.delete();
        end
    endtask

    // Called at a falling edge with the FSM idle.
    task automatic run_op(input logic [W-1:0] s, input logic [W-1:0] a, input logic t,
                          input logic [W-1:0] exp_res, input int cnt, input string name);
        src       = s;
        shamt     = a;
        shiftType = t;
        start     = 1'b1;
        sb.push_back('{exp_res, cyc + 1 + cnt});
        @(negedge clk);
        start = 1'b0;
        chk({name, "_busy"}, 32'(busy), 32'd1);
        if (cnt > 0) chk({name, "_hold"}, 32'(result), 32'(last_res));
        drain(name);
        @(negedge clk);
        chk({name, "_idle"}, 32'(busy), 32'd0);
        chk({name, "_final"}, 32'(result), 32'(exp_res));
        last_res = exp_res;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c;
        fork
            monitor();
        join_none

        // Reset asserted together with start: nothing may launch.
        src       = 16'hFFFF;
        shamt     = 16'h0001;
        start     = 1'b1;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        @(negedge clk);
        chk("rst_busy2", 32'(busy), 32'd0);
        start = 1'b0;
        reset = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) begin
            run_op(vecs[i].s, vecs[i].a, vecs[i].t, vecs[i].r, vecs[i].n, $sformatf("v%0d", i));
        end

        // Second start while busy is dropped.
        c = cyc;
        src = 16'h0003; shamt = 16'h0005; shiftType = 1'b1; start = 1'b1;
        sb.push_back('{16'h0060, c + 6});
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        src = 16'hFFFF; shamt = 16'h0000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain("busy_start");
        @(negedge clk);
        chk("busy_start_idle", 32'(busy), 32'd0);
        chk("busy_start_result", 32'(result), 32'h0060);
        last_res = 16'h0060;

        // Start presented during the DONE cycle is dropped.
        c = cyc;
        src = 16'h0003; shamt = SHAMT_LEFT1; shiftType = 1'b0; start = 1'b1;
        sb.push_back('{16'h0006, c + 2});
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        src = 16'h7777; shamt = 16'h0000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("done_start_idle", 32'(busy), 32'd0);
        drain("done_start");
        @(negedge clk);
        chk("done_start_result", 32'(result), 32'h0006);
        last_res = 16'h0006;

        // Start held high relaunches each time IDLE is reached.
        c = cyc;
        src = 16'h0101; shamt = 16'h0001; shiftType = 1'b0; start = 1'b1;
        sb.push_back('{16'h0202, c + 2});
        sb.push_back('{16'h0202, c + 5});
        sb.push_back('{16'h0202, c + 8});
        repeat (7) @(negedge clk);
        start = 1'b0;
        drain("held_start");
        @(negedge clk);
        chk("held_start_idle", 32'(busy), 32'd0);
        last_res = 16'h0202;

        // Reset mid-operation aborts with no completion.
        src = 16'h0003; shamt = 16'h0005; shiftType = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_result", 32'(result), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        reset = 1'b0;
        last_res = '0;
        repeat (10) @(negedge clk);
        chk("abort_stays_idle", 32'(busy), 32'd0);
        chk("abort_result_kept", 32'(result), 32'd0);

        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001: Parameter WIDTH, default 16, data and shift-amount width in bits.
REQ-002: clk  input  1  single system clock; all state updates on rising edge.
REQ-003: reset  input  1  synchronous, active-high reset.
REQ-004: start  input  1  request; sampled only in IDLE.
REQ-005: src  input  WIDTH  operand captured on accepted start.
REQ-006: shamt  input  WIDTH  two's-complement signed amount; positive = left, negative = right, zero = pass-through; captured on accepted start.
REQ-007: shiftType  input  1  1 = logical, 0 = arithmetic; captured on accepted start.
REQ-008: busy  output  1  high in SHIFT and DONE states.
REQ-009: done  output  1  single-cycle completion pulse.
REQ-010: result  output  WIDTH  shifted value, registered.

Function
REQ-011: The FSM SHALL have states IDLE, SHIFT and DONE.
REQ-012: In IDLE with start=1, the block SHALL capture src, shamt and shiftType, and set count = min(|shamt|, WIDTH), with |shamt| computed in WIDTH+1 bits so 0x8000 yields 32768.
REQ-013: From IDLE, the FSM SHALL go to SHIFT if count>0, else to DONE.
REQ-014: Each SHIFT cycle SHALL shift the working register exactly one bit in the captured direction and decrement count.
REQ-015: The FSM SHALL leave SHIFT for DONE on the cycle count decrements to 0.
REQ-016: Left shifts SHALL zero-fill regardless of shiftType.
REQ-017: Right shifts SHALL fill the MSB with the current MSB when shiftType=0, and with 0 when shiftType=1.
REQ-018: In DONE, done SHALL be 1 for exactly one cycle, result SHALL hold the final value, and the FSM SHALL return to IDLE next cycle.
REQ-019: Latency: with start sampled at edge 0, done SHALL be high in cycle count+1.
REQ-020: result SHALL update only on the DONE transition and SHALL hold until the next completion.
REQ-021: start SHALL be ignored while busy=1, with no queuing.
REQ-022: start asserted in the DONE cycle SHALL be ignored.
REQ-023: start held high in IDLE across completions SHALL launch a new operation each time the FSM reaches IDLE.
REQ-024: Amounts with magnitude ≥ WIDTH SHALL yield 0 for left and logical-right shifts, and all-sign-bits for arithmetic-right shifts, after WIDTH SHIFT cycles.

Reset
REQ-025: On reset=1 at a clock edge, state SHALL become IDLE and busy, done, result, count and the working register SHALL become 0.
REQ-026: Reset SHALL override start and any operation in progress in the same cycle.
REQ-027: An aborted operation SHALL produce no done pulse.
REQ-028: Outputs SHALL be valid reset values from the first edge with reset=1.

Structure
REQ-029: A shared package shifter_pkg SHALL hold the state enum and the direction encodings SHAMT_LEFT1=16'h0001 and SHAMT_RIGHT1=16'hFFFF.
REQ-030: A combinational sub-module shift_step SHALL implement the one-bit shift (inputs: value, direction, shiftType) and be instantiated once.
REQ-031: All registers SHALL reside in shift_sequencer; shift_step SHALL be purely combinational.

Verification
REQ-032: src=0x8001, shamt=0x0003, shiftType=1 -> done in cycle 4, result=0x0008.
REQ-033: src=0x8000, shamt=0xFFFC, shiftType=0 -> done in cycle 5, result=0xF800; repeat with shiftType=1 -> result=0x0800.
REQ-034: src=0x1234, shamt=0x0000 -> done in cycle 1, result=0x1234, busy high one cycle.
REQ-035: src=0x8000, shamt=0x8000, shiftType=0 -> done in cycle 17, result=0xFFFF; shamt=0x0020 -> result=0x0000 in cycle 17.
REQ-036: Start an operation with shamt=0x0005, pulse start again at cycle 2 -> single done in cycle 6, second request ignored.
REQ-037: Assert reset at cycle 2 of an operation with shamt=0x0005 -> busy=0 and result=0 next cycle, and no done pulse afterward.
